// File: rtl/timer_defs.sv
// Shared constants and state encoding for the min/sec/hour timer stages.
package timer_defs;

   localparam int MAX_SEC = 60;
   localparam int MAX_MIN = 60;
   localparam int DISP_W  = 8;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clocks; holds when disabled.
module tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] ONE  = PW'(1);

   logic [PW-1:0] pcnt_q, pcnt_d;

   assign tick = en && (pcnt_q == LAST);

   always_comb begin
      pcnt_d = pcnt_q;
      if (clr) begin
         pcnt_d = '0;
      end else if (en) begin
         pcnt_d = tick ? '0 : pcnt_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/sec_counter.sv
// Seconds stage: run/stop state, 0..MAX_SEC-1 count and wrap carry.
module sec_counter
   import timer_defs::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int MAX_SEC_P = MAX_SEC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_stop,
   input  logic              clear,
   output logic [DISP_W-1:0] sec,
   output logic              carry,
   output logic              running
);

   localparam logic [DISP_W-1:0] SEC_LAST = DISP_W'(MAX_SEC_P - 1);
   localparam logic [DISP_W-1:0] SEC_ONE  = DISP_W'(1);

   state_e            state_q, state_d;
   logic [DISP_W-1:0] sec_q, sec_d;
   logic              carry_q, carry_d;
   logic              tick;

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .en  (state_q == ST_RUN),
      .clr (clear),
      .tick(tick)
   );

   // clear outranks tick, so a clear on the wrap tick suppresses carry
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      carry_d = 1'b0;
      if (run_stop) begin
         state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
      end
      if (clear) begin
         sec_d = '0;
      end else if (tick) begin
         if (sec_q == SEC_LAST) begin
            sec_d   = '0;
            carry_d = 1'b1;
         end else begin
            sec_d = sec_q + SEC_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_STOP;
         sec_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         carry_q <= carry_d;
      end
   end

   assign sec     = sec_q;
   assign carry   = carry_q;
   assign running = (state_q == ST_RUN);

endmodule
